// File: rtl/myip_pkg.sv
// Shared definitions for the myip result-streaming blocks: frame FSM
// encoding and default RAM geometry.
package myip_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEF_RAM_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH = 3;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry FIFO that holds read data until the stream accepts it.
// The caller guarantees it never pushes into a full buffer.
module axis_skid_buf
  import myip_pkg::*;
#(
  parameter int W = DEF_RAM_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  input  logic         pop_ready,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         pop;

  assign head_valid = (count != 2'd0);
  assign head_data  = mem[rd_ptr];
  assign pop        = head_valid & pop_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_valid) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_valid} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/axis_res_streamer.sv
// Streams num_words result-RAM words onto an AXI-Stream master port.
// Handshake: a beat transfers on a cycle with TVALID and TREADY both high; TVALID/TDATA/TLAST hold until then.
module axis_res_streamer
  import myip_pkg::*;
#(
  parameter int RAM_WIDTH  = DEF_RAM_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  res_en,
  output logic [ADDR_WIDTH-1:0] res_addr,
  input  logic [RAM_WIDTH-1:0]  res_data,
  output logic                  M_AXIS_TVALID,
  output logic [31:0]           M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY
);

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH:0]   nw_q;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic [ADDR_WIDTH:0]   beat_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_pend;
  logic                  rd_pend_last;
  logic [1:0]            buf_count;
  logic [RAM_WIDTH:0]    buf_data;
  logic                  buf_valid;
  logic                  hs;
  logic                  rd_last;
  logic                  last_beat;
  logic [2:0]            occ_after;

  assign hs        = buf_valid & M_AXIS_TREADY;
  assign rd_last   = (rd_cnt + ONE) == nw_q;
  assign last_beat = hs && ((beat_cnt + ONE) == nw_q);

  // Credit for the beat leaving this cycle keeps one read per cycle in flight.
  assign occ_after = {1'b0, buf_count} + {2'b0, rd_pend} - {2'b0, hs};
  assign res_en    = (state == STREAM) && (rd_cnt < nw_q) && (occ_after < 3'd2);
  assign res_addr  = addr_q;

  assign busy          = (state == STREAM) || (state == DONE);
  assign done          = (state == DONE);
  assign M_AXIS_TVALID = buf_valid;
  assign M_AXIS_TLAST  = buf_valid & buf_data[RAM_WIDTH];
  assign M_AXIS_TDATA  = 32'(buf_data[RAM_WIDTH-1:0]);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= IDLE;
      nw_q         <= '0;
      rd_cnt       <= '0;
      beat_cnt     <= '0;
      addr_q       <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend      <= res_en;
      rd_pend_last <= res_en & rd_last;
      case (state)
        IDLE: begin
          if (start) begin
            nw_q     <= num_words;
            rd_cnt   <= '0;
            beat_cnt <= '0;
            addr_q   <= '0;
            state    <= (num_words == '0) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (res_en) begin
            rd_cnt <= rd_cnt + ONE;
            // Address parks on the final word instead of wrapping.
            if (!rd_last) begin
              addr_q <= addr_q + 1'b1;
            end
          end
          if (hs) begin
            beat_cnt <= beat_cnt + ONE;
          end
          if (last_beat) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  axis_skid_buf #(
    .W (RAM_WIDTH + 1)
  ) u_skid (
    .clk        (ACLK),
    .rst        (ARESET),
    .push_valid (rd_pend),
    .push_data  ({rd_pend_last, res_data}),
    .head_valid (buf_valid),
    .head_data  (buf_data),
    .pop_ready  (M_AXIS_TREADY),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_axis_res_streamer.sv
// Self-checking bench for axis_res_streamer: frame-level reference model,
// directed scenarios and randomized frames with random back-pressure.
module tb_axis_res_streamer;

  localparam int RW = 8;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          busy, done, res_en;
  logic [AW-1:0] res_addr;
  logic [RW-1:0] res_data = '0;
  logic          M_AXIS_TVALID, M_AXIS_TLAST;
  logic [31:0]   M_AXIS_TDATA;
  logic          M_AXIS_TREADY = 1'b1;

  always #5 ACLK = ~ACLK;

  axis_res_streamer #(.RAM_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .start         (start),
    .num_words     (num_words),
    .busy          (busy),
    .done          (done),
    .res_en        (res_en),
    .res_addr      (res_addr),
    .res_data      (res_data),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY)
  );

  // Synchronous-read result RAM
  logic [RW-1:0] ram [8];
  always @(posedge ACLK) if (res_en) res_data <= ram[res_addr];

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];          // {last, data}
  logic [31:0] got_q[$];
  logic        got_last_q[$];
  int          hs_cyc_q[$];
  int          done_cyc_q[$];
  int          busy_cnt = 0;
  int          cyc = 0;
  int          acc_cyc = -100;
  int          acc_n = 0;
  int          rd_next = 0;
  bit          in_frame = 0;
  bit          done_now = 0;
  bit          rst_prev = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  int          rdy_mode = 0;
  int          stall_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + compare ----------------
  logic [32:0] e;
  bit          last_hs;
  bit          nf, nd;

  always @(negedge ACLK) begin
    cyc++;
    if (rst_prev) begin
      chk("rst_tvalid", 32'(M_AXIS_TVALID), 0);
      chk("rst_tlast", 32'(M_AXIS_TLAST), 0);
      chk("rst_tdata", M_AXIS_TDATA, 0);
      chk("rst_res_en", 32'(res_en), 0);
      chk("rst_res_addr", 32'(res_addr), 0);
    end
    chk("busy", 32'(busy), 32'(in_frame || done_now));
    chk("done", 32'(done), 32'(done_now));
    if (busy) busy_cnt++;
    if (done) done_cyc_q.push_back(cyc);
    if (acc_n > 0 && cyc == acc_cyc + 1) chk("first_res_en", 32'(res_en), 1);
    if (acc_n > 0 && cyc == acc_cyc + 3) chk("first_tvalid", 32'(M_AXIS_TVALID), 1);
    if (prev_stall && !rst_prev) begin
      chk("stall_tvalid", 32'(M_AXIS_TVALID), 1);
      chk("stall_tdata", M_AXIS_TDATA, prev_data);
      chk("stall_tlast", 32'(M_AXIS_TLAST), 32'(prev_last));
    end
    if (res_en) begin
      chk("rd_in_frame", 32'(in_frame), 1);
      chk("rd_addr", 32'(res_addr), 32'(rd_next));
      chk("rd_range", 32'(rd_next < acc_n), 1);
      rd_next++;
    end
    last_hs = 0;
    if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected no beat (cycle %0d)", M_AXIS_TDATA, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("tdata", M_AXIS_TDATA, e[31:0]);
        chk("tlast", 32'(M_AXIS_TLAST), 32'(e[32]));
        last_hs = e[32];
      end
      got_q.push_back(M_AXIS_TDATA);
      got_last_q.push_back(M_AXIS_TLAST);
      hs_cyc_q.push_back(cyc);
    end
    nf = in_frame;
    nd = 0;
    if (last_hs) begin
      nf = 0;
      nd = 1;
    end
    if (start && !(in_frame || done_now) && !ARESET) begin
      acc_cyc = cyc;
      acc_n   = int'(num_words);
      rd_next = 0;
      for (int i = 0; i < acc_n; i++) exp_q.push_back({(i == acc_n - 1), 32'(ram[i])});
      if (acc_n == 0) nd = 1;
      else nf = 1;
    end
    if (ARESET) begin
      nf = 0;
      nd = 0;
      exp_q.delete();
      acc_n = 0;
    end
    rst_prev   = ARESET;
    prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
    prev_data  = M_AXIS_TDATA;
    prev_last  = M_AXIS_TLAST;
    in_frame   = nf;
    done_now   = nd;
  end

  // ---------------- TREADY driver ----------------
  always @(posedge ACLK) begin
    #1;
    case (rdy_mode)
      0: M_AXIS_TREADY = 1'b1;
      1: M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      2: M_AXIS_TREADY = ~M_AXIS_TREADY;
      default: begin
        if (got_q.size() == 3 && stall_cnt < 3) begin
          M_AXIS_TREADY = 1'b0;
          stall_cnt++;
        end else begin
          M_AXIS_TREADY = 1'b1;
        end
      end
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic run_frame(input int n);
    @(posedge ACLK); #1;
    start = 1'b1;
    num_words = (AW+1)'(n);
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge ACLK); #1;
      if (!in_frame && !done_now) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL idle_timeout: frame still open after 400 cycles (cycle %0d)", cyc);
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_last_q.delete();
    hs_cyc_q.delete();
    done_cyc_q.delete();
    busy_cnt = 0;
  endtask

  task automatic fill_ram_random();
    for (int i = 0; i < 8; i++) ram[i] = RW'($urandom_range(0, 255));
  endtask

  // ---------------- stimulus ----------------
  int tl_cnt;
  int seen;

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = '0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    repeat (2) @(posedge ACLK);

    // Two-word frame, no back-pressure
    ram[0] = 8'h0A; ram[1] = 8'h1B;
    rdy_mode = 0;
    clear_logs();
    run_frame(2);
    wait_idle();
    chk("s1_beats", got_q.size(), 2);
    chk("s1_beat0", got_q[0], 32'h0000000A);
    chk("s1_beat1", got_q[1], 32'h0000001B);
    chk("s1_last0", 32'(got_last_q[0]), 0);
    chk("s1_last1", 32'(got_last_q[1]), 1);
    chk("s1_back_to_back", hs_cyc_q[1] - hs_cyc_q[0], 1);
    chk("s1_done_count", done_cyc_q.size(), 1);
    chk("s1_done_time", done_cyc_q[0], hs_cyc_q[1] + 1);

    // Eight words, three-cycle stall after the third beat
    for (int i = 0; i < 8; i++) ram[i] = RW'(i + 1);
    rdy_mode = 3;
    stall_cnt = 0;
    clear_logs();
    run_frame(8);
    wait_idle();
    chk("s2_beats", got_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("s2_data", got_q[i], 32'(i + 1));
    chk("s2_pre_stall_rate", hs_cyc_q[2] - hs_cyc_q[0], 2);
    chk("s2_stall_gap", hs_cyc_q[3] - hs_cyc_q[2], 4);
    chk("s2_done_count", done_cyc_q.size(), 1);

    // Empty frame
    rdy_mode = 0;
    clear_logs();
    run_frame(0);
    wait_idle();
    chk("s3_no_beats", got_q.size(), 0);
    chk("s3_busy_cycles", busy_cnt, 1);
    chk("s3_done_count", done_cyc_q.size(), 1);
    chk("s3_done_time", done_cyc_q[0], acc_cyc + 1);

    // Start while busy is ignored
    fill_ram_random();
    clear_logs();
    run_frame(4);
    repeat (2) @(posedge ACLK);
    #1 start = 1'b1; num_words = 4'd5;
    @(posedge ACLK); #1 start = 1'b0;
    wait_idle();
    repeat (10) @(negedge ACLK);
    chk("s4_beats", got_q.size(), 4);
    chk("s4_done_count", done_cyc_q.size(), 1);

    // Reset in mid-frame, then a fresh frame restarts at address 0
    fill_ram_random();
    clear_logs();
    run_frame(4);
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge ACLK); #1;
      if (got_q.size() >= 1) seen = 1;
    end
    chk("s5_first_beat_seen", seen, 1);
    pulse_reset();
    repeat (8) @(negedge ACLK);
    chk("s5_no_done", done_cyc_q.size(), 0);
    clear_logs();
    run_frame(2);
    wait_idle();
    chk("s5_beats", got_q.size(), 2);
    chk("s5_beat0", got_q[0], 32'(ram[0]));
    chk("s5_beat1", got_q[1], 32'(ram[1]));

    // TREADY toggling every cycle
    fill_ram_random();
    rdy_mode = 2;
    clear_logs();
    run_frame(8);
    wait_idle();
    chk("s6_beats", got_q.size(), 8);
    tl_cnt = 0;
    foreach (got_last_q[i]) if (got_last_q[i]) tl_cnt++;
    chk("s6_tlast_count", tl_cnt, 1);
    chk("s6_tlast_eighth", 32'(got_last_q[7]), 1);

    // Randomized frames
    rdy_mode = 1;
    for (int f = 0; f < 25; f++) begin
      fill_ram_random();
      run_frame($urandom_range(0, 8));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 3)) @(posedge ACLK);
        #1 start = 1'b1; num_words = (AW+1)'($urandom_range(0, 8));
        @(posedge ACLK); #1 start = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 6)) @(posedge ACLK);
        pulse_reset();
      end
      wait_idle();
    end

    repeat (5) @(posedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
